// File: rtl/time_disp_pkg.sv
// Shared types and constants for the multiplexed HH.MM.SS display.
// Segment codes are active-high, bit0 = a .. bit6 = g.
package time_disp_pkg;

    typedef logic [2:0] digit_t;

    typedef enum logic [2:0] {
        DIG_S1  = 3'd0,
        DIG_S10 = 3'd1,
        DIG_M1  = 3'd2,
        DIG_M10 = 3'd3,
        DIG_H1  = 3'd4,
        DIG_H10 = 3'd5
    } digit_e;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] HR_MAX  = 6'd23;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = SEG_0;
            4'd1:    c = SEG_1;
            4'd2:    c = SEG_2;
            4'd3:    c = SEG_3;
            4'd4:    c = SEG_4;
            4'd5:    c = SEG_5;
            4'd6:    c = SEG_6;
            4'd7:    c = SEG_7;
            4'd8:    c = SEG_8;
            4'd9:    c = SEG_9;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// 6-bit binary to two BCD digits via compare-subtract, plus range check.
module bin2bcd_2digit
    import time_disp_pkg::*;
#(
    parameter logic [5:0] MAX = SEC_MAX
) (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    // Values 60..63 leave ones > 9; they are always out of range anyway
    always_comb begin
        tens = 4'd0;
        ones = bin[3:0];
        if (bin >= 6'd50) begin
            tens = 4'd5;
            ones = 4'(bin - 6'd50);
        end else if (bin >= 6'd40) begin
            tens = 4'd4;
            ones = 4'(bin - 6'd40);
        end else if (bin >= 6'd30) begin
            tens = 4'd3;
            ones = 4'(bin - 6'd30);
        end else if (bin >= 6'd20) begin
            tens = 4'd2;
            ones = 4'(bin - 6'd20);
        end else if (bin >= 6'd10) begin
            tens = 4'd1;
            ones = 4'(bin - 6'd10);
        end
    end

    assign valid = (bin <= MAX);

endmodule

// File: rtl/time_display_mux.sv
// Snapshots hr/min/sec once per frame and scans six multiplexed
// 7-segment digits with per-pair blinking and dash for bad values.
module time_display_mux
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50_000,
    parameter int BLINK_FRAMES = 250,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit HR_LZ_BLANK  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    input  logic [2:0] blink_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SCNT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [5:0] AN_OFF  = ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    logic [SW-1:0] r_scnt;
    digit_e        r_digit;
    digit_e        w_digit_nxt;
    logic          w_slot_wrap;
    logic          w_frame_end;

    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hr;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;

    logic [3:0]    w_sec_t, w_sec_o;
    logic [3:0]    w_min_t, w_min_o;
    logic [3:0]    w_hr_t, w_hr_o;
    logic          w_sec_ok, w_min_ok, w_hr_ok;

    logic [3:0]    w_val;
    logic          w_ok;
    logic [1:0]    w_pair;
    logic          w_show;
    logic [6:0]    w_code;
    logic [5:0]    w_an_on;
    logic          w_dp_on;
    logic [6:0]    w_seg;
    logic [5:0]    w_an;
    logic          w_dp;

    logic [6:0]    r_seg;
    logic [5:0]    r_an;
    logic          r_dp;
    logic          r_frame_done;

    bin2bcd_2digit #(.MAX(SEC_MAX)) u_sec (
        .bin   (r_sec),
        .tens  (w_sec_t),
        .ones  (w_sec_o),
        .valid (w_sec_ok)
    );

    bin2bcd_2digit #(.MAX(MIN_MAX)) u_min (
        .bin   (r_min),
        .tens  (w_min_t),
        .ones  (w_min_o),
        .valid (w_min_ok)
    );

    bin2bcd_2digit #(.MAX(HR_MAX)) u_hr (
        .bin   ({1'b0, r_hr}),
        .tens  (w_hr_t),
        .ones  (w_hr_o),
        .valid (w_hr_ok)
    );

    assign w_slot_wrap = (r_scnt == SCNT_LAST);
    assign w_frame_end = w_slot_wrap && (r_digit == DIG_H10);

    always_comb begin
        w_digit_nxt = r_digit;
        if (w_slot_wrap) begin
            w_digit_nxt = (r_digit == DIG_H10) ? DIG_S1
                                               : digit_e'(r_digit + 3'd1);
        end
    end

    always_comb begin
        w_val  = 4'd0;
        w_ok   = 1'b1;
        w_pair = 2'd0;
        unique case (r_digit)
            DIG_S1:  begin w_val = w_sec_o; w_ok = w_sec_ok; w_pair = 2'd0; end
            DIG_S10: begin w_val = w_sec_t; w_ok = w_sec_ok; w_pair = 2'd0; end
            DIG_M1:  begin w_val = w_min_o; w_ok = w_min_ok; w_pair = 2'd1; end
            DIG_M10: begin w_val = w_min_t; w_ok = w_min_ok; w_pair = 2'd1; end
            DIG_H1:  begin w_val = w_hr_o;  w_ok = w_hr_ok;  w_pair = 2'd2; end
            DIG_H10: begin w_val = w_hr_t;  w_ok = w_hr_ok;  w_pair = 2'd2; end
            default: ;
        endcase
        w_code = w_ok ? seg7(w_val) : SEG_DASH;
        // Slot 0 of every digit is dark so the previous digit cannot ghost
        w_show = (r_scnt != '0)
              && !(r_phase && blink_en[w_pair])
              && !(HR_LZ_BLANK && (r_digit == DIG_H10) && (r_hr < 5'd10));
        w_an_on = w_show ? (6'b1 << r_digit) : 6'b0;
        w_dp_on = (r_digit == DIG_M1) || (r_digit == DIG_H1);
        w_seg   = ACTIVE_LOW ? ~w_code  : w_code;
        w_an    = ACTIVE_LOW ? ~w_an_on : w_an_on;
        w_dp    = ACTIVE_LOW ? ~w_dp_on : w_dp_on;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scnt       <= '0;
            r_digit      <= DIG_S1;
            r_sec        <= '0;
            r_min        <= '0;
            r_hr         <= '0;
            r_fcnt       <= '0;
            r_phase      <= 1'b0;
            r_seg        <= SEG_OFF;
            r_an         <= AN_OFF;
            r_dp         <= DP_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_scnt       <= w_slot_wrap ? '0 : r_scnt + 1'b1;
            r_digit      <= w_digit_nxt;
            r_seg        <= w_seg;
            r_an         <= w_an;
            r_dp         <= w_dp;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_sec <= sec;
                r_min <= min;
                r_hr  <= hr;
                if (r_fcnt == FCNT_LAST) begin
                    r_fcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_time_display_mux.sv
// Scoreboard bench: per-frame expected digits come from a decimal model
// of the displayed time; a monitor pops one entry per lit output cycle.
module tb_time_display_mux;

    localparam int SD    = 4;
    localparam int BF    = 2;
    localparam int FRAME = SD * 6;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [2:0] blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    time_display_mux #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1'b1),
        .HR_LZ_BLANK  (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sec        (sec),
        .min        (min),
        .hr         (hr),
        .blink_en   (blink_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   k;
    bit   rnd;
    logic [5:0] snap_s, snap_m, p_s, p_m, f_s, f_m;
    logic [4:0] snap_h, p_h, f_h;
    logic [2:0] f_be;
    logic [6:0] segtab [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] rfield(input int mx, input int top);
        if ($urandom_range(0, 9) < 8)
            return 6'($urandom_range(0, mx));
        return 6'($urandom_range(mx + 1, top));
    endfunction

    // Expected lit cycles for frame f, from the decimal value of each field
    task automatic push_frame(input int f);
        int         v;
        int         mx;
        bit         ph;
        logic [6:0] code;
        exp_t       e;
        ph = ((f / BF) % 2) == 1;
        for (int d = 0; d < 6; d++) begin
            v  = (d < 2) ? int'(snap_s) : (d < 4) ? int'(snap_m) : int'(snap_h);
            mx = (d < 4) ? 59 : 23;
            if (ph && blink_en[d / 2]) continue;
            if (v > mx) code = 7'b1000000;
            else code = segtab[(d % 2 == 0) ? (v % 10) : (v / 10)];
            e.an  = ~(6'd1 << d);
            e.seg = ~code;
            e.dp  = !((d == 2) || (d == 4));
            for (int c = 1; c < SD; c++) q.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (k % FRAME == 0) begin
                if (k > 0) begin
                    snap_s = p_s;
                    snap_m = p_m;
                    snap_h = p_h;
                end
                blink_en = rnd ? 3'($urandom_range(0, 7)) : f_be;
                push_frame(k / FRAME);
            end
            if (rnd) begin
                sec = rfield(59, 63);
                min = rfield(59, 63);
                hr  = 5'(rfield(23, 31));
            end else begin
                sec = f_s;
                min = f_m;
                hr  = f_h;
            end
            p_s = sec;
            p_m = min;
            p_h = hr;
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int   n;
        exp_t e;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                n = 0;
                continue;
            end
            n++;
            if (frame_done || (n % FRAME == 0))
                chk("frame_done", 16'(frame_done), 16'(n % FRAME == 0));
            if (an != 6'h3F) begin
                if (q.size() == 0) begin
                    chk("unexpected_digit", 16'(an), 16'h003F);
                end else begin
                    e = q.pop_front();
                    chk("scan_an", 16'(an), 16'(e.an));
                    chk("scan_seg", 16'(seg), 16'(e.seg));
                    chk("scan_dp", 16'(dp), 16'(e.dp));
                end
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        sec      = '0;
        min      = '0;
        hr       = '0;
        blink_en = '0;
        k        = 0;
        rnd      = 1'b0;
        f_be     = '0;
        f_s = '0; f_m = '0; f_h = '0;
        p_s = '0; p_m = '0; p_h = '0;
        snap_s = '0; snap_m = '0; snap_h = '0;
        repeat (3) @(negedge clk);
        chk("reset_seg", 16'(seg), 16'h007F);
        chk("reset_an", 16'(an), 16'h003F);
        chk("reset_dp", 16'(dp), 16'h0001);
        chk("reset_frame_done", 16'(frame_done), 16'h0000);
        reset_n = 1'b1;

        f_s = 6'd56; f_m = 6'd34; f_h = 5'd12;
        run(FRAME);
        run(FRAME + 8);
        f_s = 6'd57;
        run(16);
        f_s = 6'd60; f_m = 6'd5; f_h = 5'd23;
        run(2 * FRAME);
        f_s = 6'd56; f_m = 6'd34; f_h = 5'd12; f_be = 3'b100;
        run(4 * FRAME);
        rnd = 1'b1;
        run(30 * FRAME);
        rnd = 1'b0;
        f_be = 3'b000;
        run(14);

        // Now in slot d=3, scnt=2: reset must blank outputs without a clock
        reset_n = 1'b0;
        #1;
        chk("async_an", 16'(an), 16'h003F);
        chk("async_seg", 16'(seg), 16'h007F);
        chk("async_dp", 16'(dp), 16'h0001);
        @(negedge clk);
        chk("async_frame_done", 16'(frame_done), 16'h0000);
        q.delete();
        k = 0;
        snap_s = '0; snap_m = '0; snap_h = '0;
        reset_n = 1'b1;
        rnd = 1'b1;
        run(3 * FRAME);
        @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
